// File: rtl/video_crop_ctrl.sv
// Crop-window configuration controller: measures frame geometry from en/vs,
// and publishes a clamped copy of the pending window only during vertical blanking.
module video_crop_ctrl #(
    parameter logic [15:0] MAX_DIM = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_in,
    input  logic        vs_in,
    input  logic        cfg_enable,
    input  logic [15:0] cfg_x,
    input  logic [15:0] cfg_y,
    input  logic [15:0] cfg_w,
    input  logic [15:0] cfg_h,
    input  logic        cfg_wr,
    output logic [15:0] CROP_X,
    output logic [15:0] CROP_Y,
    output logic [15:0] CROP_W,
    output logic [15:0] CROP_H,
    output logic [15:0] frame_w,
    output logic [15:0] frame_h,
    output logic        geom_valid,
    output logic        pending,
    output logic        clamped,
    output logic        range_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_APPLY   = 2'd2;

    localparam logic [15:0] BYPASS_LEN = 16'hFFFF;

    logic [1:0]  state_reg;
    logic        en_d;
    logic        vs_d;
    logic        idle_armed_reg;
    logic        enable_reg;
    logic [15:0] lcnt_reg;
    logic [15:0] last_w_reg;
    logic [15:0] rcnt_reg;
    logic        geom_valid_reg;
    logic        pending_reg;
    logic        clamped_reg;
    logic        range_err_reg;

    // Index 0 is the horizontal axis (x/w/frame_w), index 1 the vertical axis.
    logic [15:0] pend_org_reg  [2];
    logic [15:0] pend_len_reg  [2];
    logic [15:0] frame_dim_reg [2];
    logic [15:0] crop_org_reg  [2];
    logic [15:0] crop_len_reg  [2];

    logic        vs_fall;
    logic        vs_rise;
    logic        en_rise;
    logic        en_fall;

    logic [1:0]  axis_bad;
    logic [1:0]  axis_cut;
    logic [15:0] fit_len [2];
    logic        window_bad;
    logic        window_cut;

    assign vs_fall = vs_d & ~vs_in;
    assign vs_rise = ~vs_d & vs_in;
    assign en_rise = ~en_d & en_in;
    assign en_fall = en_d & ~en_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic [16:0] span;
            assign span         = {1'b0, pend_org_reg[gi]} + {1'b0, pend_len_reg[gi]};
            assign axis_bad[gi] = (pend_org_reg[gi] >= frame_dim_reg[gi]) ||
                                  (pend_len_reg[gi] == 16'd0);
            assign axis_cut[gi] = span > {1'b0, frame_dim_reg[gi]};
            assign fit_len[gi]  = axis_cut[gi] ? (frame_dim_reg[gi] - pend_org_reg[gi])
                                               : pend_len_reg[gi];
        end
    endgenerate

    assign window_bad = |axis_bad;
    assign window_cut = |axis_cut;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_d       <= 1'b0;
            vs_d       <= 1'b0;
            enable_reg <= 1'b0;
            lcnt_reg   <= 16'd0;
            last_w_reg <= 16'd0;
            rcnt_reg   <= 16'd0;
        end else begin
            en_d       <= en_in;
            vs_d       <= vs_in;
            enable_reg <= cfg_enable;

            if (en_rise) begin
                lcnt_reg <= 16'd1;
            end else if (en_in && (lcnt_reg != MAX_DIM)) begin
                lcnt_reg <= lcnt_reg + 16'd1;
            end

            if (en_fall) begin
                last_w_reg <= lcnt_reg;
            end

            if (!vs_in) begin
                rcnt_reg <= 16'd0;
            end else if (en_rise && (rcnt_reg != MAX_DIM)) begin
                rcnt_reg <= rcnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pend_org_reg[i] <= 16'd0;
                pend_len_reg[i] <= 16'd0;
            end
        end else if (cfg_wr) begin
            // A write on the apply cycle wins over the clear and stays pending.
            pending_reg     <= 1'b1;
            pend_org_reg[0] <= cfg_x;
            pend_org_reg[1] <= cfg_y;
            pend_len_reg[0] <= cfg_w;
            pend_len_reg[1] <= cfg_h;
        end else if (state_reg == S_APPLY) begin
            pending_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            idle_armed_reg <= 1'b0;
            geom_valid_reg <= 1'b0;
            clamped_reg    <= 1'b0;
            range_err_reg  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                frame_dim_reg[i] <= 16'd0;
                crop_org_reg[i]  <= 16'd0;
                crop_len_reg[i]  <= BYPASS_LEN;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // Only a rise preceded by blanking starts a frame, so a frame
                    // already in progress when reset releases is never measured.
                    if (!vs_in) begin
                        idle_armed_reg <= 1'b1;
                    end
                    if (vs_rise && idle_armed_reg) begin
                        state_reg <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (vs_fall) begin
                        frame_dim_reg[0] <= last_w_reg;
                        frame_dim_reg[1] <= rcnt_reg;
                        geom_valid_reg   <= 1'b1;
                        state_reg        <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    // The held window is re-validated every boundary, so enable
                    // toggles and geometry changes take effect without a new write.
                    if (!enable_reg) begin
                        for (int i = 0; i < 2; i++) begin
                            crop_org_reg[i] <= 16'd0;
                            crop_len_reg[i] <= BYPASS_LEN;
                        end
                        clamped_reg   <= 1'b0;
                        range_err_reg <= 1'b0;
                    end else if (window_bad) begin
                        clamped_reg   <= 1'b0;
                        range_err_reg <= 1'b1;
                    end else begin
                        for (int i = 0; i < 2; i++) begin
                            crop_org_reg[i] <= pend_org_reg[i];
                            crop_len_reg[i] <= fit_len[i];
                        end
                        clamped_reg   <= window_cut;
                        range_err_reg <= 1'b0;
                    end
                    state_reg <= S_MEASURE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign CROP_X     = crop_org_reg[0];
    assign CROP_Y     = crop_org_reg[1];
    assign CROP_W     = crop_len_reg[0];
    assign CROP_H     = crop_len_reg[1];
    assign frame_w    = frame_dim_reg[0];
    assign frame_h    = frame_dim_reg[1];
    assign geom_valid = geom_valid_reg;
    assign pending    = pending_reg;
    assign clamped    = clamped_reg;
    assign range_err  = range_err_reg;

endmodule

// File: tb/tb_video_crop_ctrl.sv
// Directed bench for video_crop_ctrl: 8-line x 64-cycle frames, window writes,
// clamping, rejection, apply-cycle writes and mid-frame reset.
module tb_video_crop_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_in;
    logic        vs_in;
    logic        cfg_enable;
    logic [15:0] cfg_x;
    logic [15:0] cfg_y;
    logic [15:0] cfg_w;
    logic [15:0] cfg_h;
    logic        cfg_wr;
    logic [15:0] CROP_X;
    logic [15:0] CROP_Y;
    logic [15:0] CROP_W;
    logic [15:0] CROP_H;
    logic [15:0] frame_w;
    logic [15:0] frame_h;
    logic        geom_valid;
    logic        pending;
    logic        clamped;
    logic        range_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [15:0] exp_x;
    logic [15:0] exp_y;
    logic [15:0] exp_w;
    logic [15:0] exp_h;

    always #5 clk = ~clk;

    video_crop_ctrl #(.MAX_DIM(16'hFFFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_in      (en_in),
        .vs_in      (vs_in),
        .cfg_enable (cfg_enable),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_w      (cfg_w),
        .cfg_h      (cfg_h),
        .cfg_wr     (cfg_wr),
        .CROP_X     (CROP_X),
        .CROP_Y     (CROP_Y),
        .CROP_W     (CROP_W),
        .CROP_H     (CROP_H),
        .frame_w    (frame_w),
        .frame_h    (frame_h),
        .geom_valid (geom_valid),
        .pending    (pending),
        .clamped    (clamped),
        .range_err  (range_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_crop(input string tag);
        chk({tag, ".x"}, CROP_X, exp_x);
        chk({tag, ".y"}, CROP_Y, exp_y);
        chk({tag, ".w"}, CROP_W, exp_w);
        chk({tag, ".h"}, CROP_H, exp_h);
    endtask

    task automatic set_exp(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] w, input logic [15:0] h);
        exp_x = x;
        exp_y = y;
        exp_w = w;
        exp_h = h;
    endtask

    task automatic wr(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] w, input logic [15:0] h);
        cfg_x  = x;
        cfg_y  = y;
        cfg_w  = w;
        cfg_h  = h;
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        $display("write x=%0d y=%0d w=%0d h=%0d pending=%0b", x, y, w, h, pending);
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            en_in = 1'b1;
            repeat (64) tick();
            en_in = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic vs_on();
        vs_in = 1'b1;
        repeat (3) tick();
    endtask

    // Drops vs; the window must hold one cycle after the low sample and be
    // updated after the next one. Optionally writes on the apply cycle.
    task automatic boundary(input bit apply_wr, input logic [15:0] ax, input logic [15:0] ay,
                            input logic [15:0] aw, input logic [15:0] ah);
        vs_in = 1'b0;
        tick();
        chk("hold_at_vs_fall.x", CROP_X, exp_x);
        chk("hold_at_vs_fall.w", CROP_W, exp_w);
        if (apply_wr) begin
            cfg_x  = ax;
            cfg_y  = ay;
            cfg_w  = aw;
            cfg_h  = ah;
            cfg_wr = 1'b1;
        end
        tick();
        cfg_wr = 1'b0;
        repeat (4) tick();
        $display("boundary crop=%0d/%0d/%0d/%0d frame=%0dx%0d gv=%0b pend=%0b clamp=%0b rerr=%0b",
                 CROP_X, CROP_Y, CROP_W, CROP_H, frame_w, frame_h, geom_valid,
                 pending, clamped, range_err);
    endtask

    initial begin
        rst_n      = 1'b0;
        en_in      = 1'b0;
        vs_in      = 1'b0;
        cfg_enable = 1'b0;
        cfg_x      = 16'd0;
        cfg_y      = 16'd0;
        cfg_w      = 16'd0;
        cfg_h      = 16'd0;
        cfg_wr     = 1'b0;
        set_exp(16'd0, 16'd0, 16'hFFFF, 16'hFFFF);

        // Reset state
        repeat (3) tick();
        chk_crop("reset");
        chk("reset.frame_w", frame_w, 16'd0);
        chk("reset.frame_h", frame_h, 16'd0);
        chk("reset.geom_valid", geom_valid, 16'd0);
        chk("reset.pending", pending, 16'd0);
        chk("reset.clamped", clamped, 16'd0);
        chk("reset.range_err", range_err, 16'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Two plain frames, bypass
        for (int f = 0; f < 2; f++) begin
            vs_on();
            lines(8);
            boundary(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
            chk("plain.frame_w", frame_w, 16'd64);
            chk("plain.frame_h", frame_h, 16'd8);
            chk("plain.geom_valid", geom_valid, 16'd1);
            chk("plain.pending", pending, 16'd0);
            chk_crop("plain");
        end

        // Fitting window written mid-frame
        cfg_enable = 1'b1;
        vs_on();
        lines(3);
        wr(16'd8, 16'd2, 16'd32, 16'd4);
        chk("mid.pending", pending, 16'd1);
        chk_crop("mid.unchanged");
        lines(5);
        chk_crop("late.unchanged");
        boundary(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        set_exp(16'd8, 16'd2, 16'd32, 16'd4);
        chk_crop("fit");
        chk("fit.pending", pending, 16'd0);
        chk("fit.clamped", clamped, 16'd0);
        chk("fit.range_err", range_err, 16'd0);

        // Window overhanging both edges
        vs_on();
        lines(2);
        wr(16'd48, 16'd6, 16'd32, 16'd4);
        lines(6);
        boundary(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        set_exp(16'd48, 16'd6, 16'd16, 16'd2);
        chk_crop("clamp");
        chk("clamp.clamped", clamped, 16'd1);
        chk("clamp.range_err", range_err, 16'd0);

        // Origin at frame_w: rejected, previous window retained
        vs_on();
        lines(4);
        wr(16'd64, 16'd0, 16'd8, 16'd8);
        lines(4);
        boundary(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        chk_crop("reject");
        chk("reject.range_err", range_err, 16'd1);
        chk("reject.clamped", clamped, 16'd0);
        chk("reject.pending", pending, 16'd0);

        // Valid write clears range_err
        vs_on();
        lines(4);
        wr(16'd8, 16'd2, 16'd32, 16'd4);
        lines(4);
        boundary(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        set_exp(16'd8, 16'd2, 16'd32, 16'd4);
        chk_crop("recover");
        chk("recover.range_err", range_err, 16'd0);

        // Last write wins; a write on the apply cycle stays pending
        vs_on();
        lines(2);
        wr(16'd4, 16'd0, 16'd16, 16'd4);
        lines(2);
        wr(16'd10, 16'd1, 16'd20, 16'd3);
        lines(4);
        boundary(1'b1, 16'd2, 16'd2, 16'd8, 16'd2);
        set_exp(16'd10, 16'd1, 16'd20, 16'd3);
        chk_crop("lastwins");
        chk("lastwins.pending", pending, 16'd1);
        chk("lastwins.clamped", clamped, 16'd0);

        // The apply-cycle write lands at the following boundary
        vs_on();
        lines(8);
        boundary(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        set_exp(16'd2, 16'd2, 16'd8, 16'd2);
        chk_crop("deferred");
        chk("deferred.pending", pending, 16'd0);

        // Mid-frame reset
        vs_on();
        lines(3);
        rst_n = 1'b0;
        repeat (2) tick();
        set_exp(16'd0, 16'd0, 16'hFFFF, 16'hFFFF);
        chk_crop("midrst");
        chk("midrst.geom_valid", geom_valid, 16'd0);
        chk("midrst.frame_w", frame_w, 16'd0);
        chk("midrst.pending", pending, 16'd0);
        rst_n      = 1'b1;
        cfg_enable = 1'b0;
        lines(5);
        boundary(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        chk("truncated.geom_valid", geom_valid, 16'd0);
        chk("truncated.frame_w", frame_w, 16'd0);
        chk("truncated.frame_h", frame_h, 16'd0);
        chk_crop("truncated");
        vs_on();
        lines(8);
        boundary(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        chk("full.geom_valid", geom_valid, 16'd1);
        chk("full.frame_w", frame_w, 16'd64);
        chk("full.frame_h", frame_h, 16'd8);
        chk_crop("full");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
